// File: rtl/bus_slave_router.sv
// 1-to-4 address decoder/router downstream of the bus arbitrator.
// Terminates unmapped or hung accesses with an error response and keeps sticky error state.
module bus_slave_router #(
    parameter logic [31:0] S0_BASE  = 32'h0000_0000,
    parameter logic [31:0] S0_MASK  = 32'hF000_0000,
    parameter logic [31:0] S1_BASE  = 32'h2000_0000,
    parameter logic [31:0] S1_MASK  = 32'hF000_0000,
    parameter logic [31:0] S2_BASE  = 32'h8000_0000,
    parameter logic [31:0] S2_MASK  = 32'hF000_0000,
    parameter logic [31:0] S3_BASE  = 32'h9000_0000,
    parameter logic [31:0] S3_MASK  = 32'hF000_0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic [3:0]  s_we,
    output logic [3:0]  s_rd,
    input  logic [31:0] s_spo0,
    input  logic [31:0] s_spo1,
    input  logic [31:0] s_spo2,
    input  logic [31:0] s_spo3,
    input  logic [3:0]  s_ready,
    input  logic        err_clr,
    output logic        err_valid,
    output logic        err_ovf,
    output logic [31:0] err_addr,
    output logic        err_we,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, ACTIVE, ERR, HOLD} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [1:0]  sel, sel_nx;
    logic [15:0] cnt, cnt_nx;
    logic        req;
    logic [3:0]  hit;
    logic [3:0]  sel_oh;
    logic [31:0] sel_spo;
    logic        timeout_hit;
    logic        err_event;

    assign s_a = a;
    assign s_d = d;
    assign irq = err_valid;
    assign req = rd | we;

    assign hit[0] = (a & S0_MASK) == S0_BASE;
    assign hit[1] = (a & S1_MASK) == S1_BASE;
    assign hit[2] = (a & S2_MASK) == S2_BASE;
    assign hit[3] = (a & S3_MASK) == S3_BASE;

    assign sel_oh      = 4'b0001 << sel;
    assign timeout_hit = (cnt == CNT_LAST);

    always_comb begin
        case (sel)
            2'd0:    sel_spo = s_spo0;
            2'd1:    sel_spo = s_spo1;
            2'd2:    sel_spo = s_spo2;
            default: sel_spo = s_spo3;
        endcase
    end

    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        cnt_nx    = cnt;
        s_rd      = 4'b0;
        s_we      = 4'b0;
        ready     = 1'b0;
        spo       = 32'h0;
        err_event = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (|hit) begin
                        state_nx = ACTIVE;
                        cnt_nx   = 16'h0;
                        // lowest index wins when regions overlap
                        if (hit[0])      sel_nx = 2'd0;
                        else if (hit[1]) sel_nx = 2'd1;
                        else if (hit[2]) sel_nx = 2'd2;
                        else             sel_nx = 2'd3;
                    end else begin
                        state_nx = ERR;
                    end
                end
            end
            ACTIVE: begin
                cnt_nx = cnt + 16'd1;
                if (!req) begin
                    state_nx = IDLE;
                end else if (s_ready[sel] || !timeout_hit) begin
                    // rd together with we is a write
                    s_rd = sel_oh & {4{rd & ~we}};
                    s_we = sel_oh & {4{we}};
                    if (s_ready[sel]) begin
                        ready    = 1'b1;
                        spo      = sel_spo;
                        state_nx = HOLD;
                    end
                end else begin
                    ready     = 1'b1;
                    spo       = ERR_DATA;
                    err_event = 1'b1;
                    state_nx  = HOLD;
                end
            end
            ERR: begin
                ready     = 1'b1;
                spo       = ERR_DATA;
                err_event = 1'b1;
                state_nx  = HOLD;
            end
            HOLD: begin
                // wait for the master to release so the same access is not reissued
                if (!req) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            cnt   <= 16'h0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            cnt   <= cnt_nx;
        end
    end

    // a new error in the same cycle as err_clr becomes the first error
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_ovf   <= 1'b0;
            err_addr  <= 32'h0;
            err_we    <= 1'b0;
        end else if (err_event) begin
            if (!err_valid || err_clr) begin
                err_valid <= 1'b1;
                err_ovf   <= 1'b0;
                err_addr  <= a;
                err_we    <= we;
            end else begin
                err_ovf <= 1'b1;
            end
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_ovf   <= 1'b0;
            err_addr  <= 32'h0;
            err_we    <= 1'b0;
        end
    end
endmodule
